// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator with a shared period counter and double-buffered duty/top.
// Optional per-channel output inversion when PWM_POLARITY_EN is defined.
module pwm_multi_generator #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    top,
  input  logic                duty_wr,
  input  logic [CW-1:0]       duty_ch,
  input  logic [WIDTH-1:0]    duty_data,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0] polarity,
`endif
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    top_q;
  logic [WIDTH-1:0]    duty_s [CHANNELS];
  logic [WIDTH-1:0]    duty_a [CHANNELS];
  logic [CHANNELS-1:0] cmp;
  logic [CHANNELS-1:0] pol;
  logic                wrap;
  logic                load;

  assign wrap = (cnt == top_q);
  // Active registers track the shadows continuously while stopped.
  assign load = !enable || wrap;

  always_comb begin
    cmp = '0;
    for (int k = 0; k < CHANNELS; k++)
      cmp[k] = (cnt < duty_a[k]);
  end

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] polarity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      polarity_q <= '0;
    else if (load)
      polarity_q <= polarity;
  end

  assign pol = polarity_q;
`else
  assign pol = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      top_q <= '1;
    end else begin
      if (!enable || wrap)
        cnt <= '0;
      else
        cnt <= cnt + WIDTH'(1);
      if (load)
        top_q <= top;
    end
  end

  // Indices without a matching channel fall through untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++)
        duty_s[k] <= '0;
    end else if (duty_wr) begin
      for (int k = 0; k < CHANNELS; k++)
        if (duty_ch == CW'(k))
          duty_s[k] <= duty_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++)
        duty_a[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < CHANNELS; k++)
        duty_a[k] <= duty_s[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= enable ? (cmp ^ pol) : '0;
      period_start <= enable && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Directed bench for pwm_multi_generator (CHANNELS=4, WIDTH=8).
// Counts high cycles per channel over period-aligned windows.
module tb_pwm_multi_generator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] top;
  logic       duty_wr;
  logic [1:0] duty_ch;
  logic [7:0] duty_data;
  logic [3:0] pol;
  logic [3:0] pwm_out;
  logic       period_start;

  int n_pass;
  int n_total;
  int hi [4];
  int ps_cnt;
  int exp_hi [4];

  pwm_multi_generator #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .top          (top),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_data    (duty_data),
`ifdef PWM_POLARITY_EN
    .polarity     (pol),
`endif
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) hi[k] = 0;
    ps_cnt = 0;
  endtask

  // Samples the current cycle, then advances one clock, n times.
  task automatic measure(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) hi[k] += int'(pwm_out[k]);
      ps_cnt += int'(period_start);
      step();
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    duty_wr   = 1'b1;
    duty_ch   = ch;
    duty_data = d;
    step();
    duty_wr   = 1'b0;
  endtask

  task automatic check_window(input string tag, input int eps);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (hi[k] !== exp_hi[k])
        $display("FAIL %s ch%0d high: got %0d want %0d", tag, k, hi[k], exp_hi[k]);
      else
        n_pass++;
    end
    n_total++;
    if (ps_cnt !== eps)
      $display("FAIL %s period_start count: got %0d want %0d", tag, ps_cnt, eps);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    step();
    n_total++;
    if (pwm_out !== 4'b0000)
      $display("FAIL reset pwm_out: got %b want 0000", pwm_out);
    else n_pass++;
    n_total++;
    if (period_start !== 1'b0)
      $display("FAIL reset period_start: got %b want 0", period_start);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    top = 8'd99;
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd25);
    wr(2'd2, 8'd50);
    wr(2'd3, 8'd100);
    step();
    n_total++;
    if (pwm_out !== 4'b0000 || period_start !== 1'b0)
      $display("FAIL disabled outputs: got %b/%b want 0000/0", pwm_out, period_start);
    else n_pass++;
    enable = 1'b1;
    step();
    n_total++;
    if (period_start !== 1'b1)
      $display("FAIL first period_start: got %b want 1", period_start);
    else n_pass++;
    n_total++;
    if (pwm_out !== 4'b1110)
      $display("FAIL first pwm_out: got %b want 1110", pwm_out);
    else n_pass++;
    clr(); measure(100);
    exp_hi = '{0, 25, 50, 100};
    check_window("basic_p1", 1);
    clr(); measure(100);
    check_window("basic_p2", 1);
  endtask

  task automatic test_duty_change();
    clr();
    measure(40);
    duty_wr = 1'b1; duty_ch = 2'd1; duty_data = 8'd75;
    measure(1);
    duty_wr = 1'b0;
    measure(59);
    exp_hi = '{0, 25, 50, 100};
    check_window("chg_cur", 1);
    clr(); measure(100);
    exp_hi = '{0, 75, 50, 100};
    check_window("chg_next", 1);
  endtask

  task automatic test_wrap_write();
    clr();
    measure(98);
    duty_wr = 1'b1; duty_ch = 2'd2; duty_data = 8'd10;
    measure(1);
    duty_wr = 1'b0;
    measure(1);
    exp_hi = '{0, 75, 50, 100};
    check_window("wrap_cur", 1);
    clr(); measure(100);
    check_window("wrap_old", 1);
    clr(); measure(100);
    exp_hi = '{0, 75, 10, 100};
    check_window("wrap_new", 1);
  endtask

  task automatic test_top_change();
    clr();
    duty_wr = 1'b1; duty_ch = 2'd2; duty_data = 8'd50;
    measure(1);
    duty_wr = 1'b0;
    measure(49);
    top = 8'd9;
    measure(50);
    exp_hi = '{0, 75, 10, 100};
    check_window("top_cur", 1);
    clr(); measure(10);
    exp_hi = '{0, 10, 10, 10};
    check_window("top_p1", 1);
    clr(); measure(20);
    exp_hi = '{0, 20, 20, 20};
    check_window("top_p2", 2);
  endtask

  task automatic test_top_zero();
    top = 8'd0;
    clr(); measure(10);
    clr(); measure(8);
    exp_hi = '{0, 8, 8, 8};
    check_window("top0", 8);
  endtask

  task automatic test_disable();
    enable = 1'b0;
    step();
    n_total++;
    if (pwm_out !== 4'b0000 || period_start !== 1'b0)
      $display("FAIL disable: got %b/%b want 0000/0", pwm_out, period_start);
    else n_pass++;
    top = 8'd99;
    step();
    enable = 1'b1;
    step();
    n_total++;
    if (period_start !== 1'b1 || pwm_out !== 4'b1110)
      $display("FAIL reenable: got %b/%b want 1110/1", pwm_out, period_start);
    else n_pass++;
    clr(); measure(100);
    exp_hi = '{0, 75, 50, 100};
    check_window("reenable", 1);
  endtask

  task automatic test_reset_mid();
    wr(2'd0, 8'd60);
    measure(30);
    reset = 1'b1;
    #2;
    n_total++;
    if (pwm_out !== 4'b0000 || period_start !== 1'b0)
      $display("FAIL async reset: got %b/%b want 0000/0", pwm_out, period_start);
    else n_pass++;
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    enable = 1'b1;
    step();
    n_total++;
    if (period_start !== 1'b1 || pwm_out !== 4'b0000)
      $display("FAIL post reset: got %b/%b want 0000/1", pwm_out, period_start);
    else n_pass++;
    clr(); measure(100);
    exp_hi = '{0, 0, 0, 0};
    check_window("post_reset", 1);
  endtask

`ifdef PWM_POLARITY_EN
  task automatic test_polarity();
    enable = 1'b0;
    top = 8'd99;
    pol = 4'b0010;
    wr(2'd1, 8'd25);
    step();
    enable = 1'b1;
    step();
    clr(); measure(100);
    exp_hi = '{0, 75, 0, 0};
    check_window("polarity", 1);
    enable = 1'b0;
    step();
    n_total++;
    if (pwm_out !== 4'b0000)
      $display("FAIL polarity disable: got %b want 0000", pwm_out);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    enable = 1'b0;
    top = 8'd99;
    duty_wr = 1'b0;
    duty_ch = 2'd0;
    duty_data = 8'd0;
    pol = 4'b0000;
    test_reset();
    test_basic();
    test_duty_change();
    test_wrap_write();
    test_top_change();
    test_top_zero();
    test_disable();
    test_reset_mid();
`ifdef PWM_POLARITY_EN
    test_polarity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
